instr_fetch_unit: RTL and testbench

//  Producer side of the instruction interface: fetches 32-bit ARM words from instruction memory and presents them,

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 50 +++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// State encoding, buffer entry layout and the idle instruction.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO holding fetched words with their addresses.
// Flush wins over a same-cycle push; head is read straight from storage.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rd];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  // Pointer and occupancy tracking; flush empties in one cycle.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  // Entry storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem request feeding a prefetch buffer.
// Redirects flush the buffer and drop any in-flight word.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  input  logic        InstrTake,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_last_pc;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_valid;
  logic          w_pop;
  logic          w_redir;
  logic          w_issue;
  logic          w_push;
  logic          w_room;
  logic [31:0]   w_target;

  assign w_pop        = InstrTake && w_valid;
  assign w_redir      = w_pop && PCSrc;
  assign w_target     = BranchTarget & ~32'h3;
  assign w_room       = (w_count < CW'(DEPTH));
  assign w_push_entry = '{instr: imem_rdata, pc: r_req_addr};

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  // Next state: redirect beats both issue and push.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_redir && w_room) begin
          w_state_nxt = WAIT;
          w_issue     = 1'b1;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          w_state_nxt = IDLE;
          w_push      = !w_redir;
        end else if (w_redir) begin
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, fetch pointer and held request address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_redir)      r_fetch_pc <= w_target;
      else if (w_issue) r_fetch_pc <= r_fetch_pc + PC_STEP;
      if (w_issue)      r_req_addr <= r_fetch_pc;
    end
  end

  // Remember the head address so PC holds while the buffer is empty.
  always_ff @(posedge clk) begin
    if (reset)        r_last_pc <= '0;
    else if (w_valid) r_last_pc <= w_head.pc;
  end

  assign imem_req   = (r_state != IDLE);
  assign imem_addr  = r_req_addr;
  assign InstrValid = w_valid;
  assign Instr      = w_valid ? w_head.instr : NOP_INSTR;
  assign PC         = w_valid ? w_head.pc : r_last_pc;
  assign PCPlus8    = PC + 32'd8;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Memory model with variable latency plus an expected-instruction queue.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] Instr, PC, PCPlus8;
  logic        InstrValid;
  logic        InstrTake = 1'b0, PCSrc = 1'b0;
  logic [31:0] BranchTarget = '0;

  logic        req_b, ack_b = 1'b0, valid_b, take_b = 1'b0;
  logic [31:0] addr_b, rdata_b = '0, instr_b, pc_b, pc8_b;

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instr(Instr), .InstrValid(InstrValid),
    .PC(PC), .PCPlus8(PCPlus8),
    .InstrTake(InstrTake), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata_b),
    .Instr(instr_b), .InstrValid(valid_b),
    .PC(pc_b), .PCPlus8(pc8_b),
    .InstrTake(take_b), .PCSrc(1'b0),
    .BranchTarget(32'h0)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          lat;
    int          pops;
    logic [31:0] last_pc;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  exp_t        q[$];
  logic [31:0] exp_addr = '0;
  int          lat = 1;
  int          lat_cnt = 0;
  bit          drop_pend = 0;
  bit          b_en = 0;
  int          n_pops = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_pc8 = '0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic cyc(input bit take, input bit src,
                     input logic [31:0] tgt);
    bit          ack_now;
    bit          redir;
    bit          pr_req;
    bit          pr_ack;
    bit          pr_rst;
    logic [31:0] pr_addr;
    ack_now      = !reset && imem_req && (lat_cnt >= lat);
    imem_ack     = ack_now;
    imem_rdata   = ack_now ? memfn(imem_addr) : 32'h0;
    InstrTake    = take;
    PCSrc        = src;
    BranchTarget = tgt;
    ack_b        = !reset && req_b && b_en;
    rdata_b      = memfn(addr_b);
    take_b       = b_en;
    if (!reset) begin
      chk("valid_vs_sb", {31'b0, InstrValid}, {31'b0, q.size() != 0});
      if (InstrValid && q.size() != 0) begin
        chk("head_pc", PC, q[0].pc);
        chk("head_instr", Instr, q[0].instr);
        chk("head_pc8", PCPlus8, q[0].pc + 32'd8);
      end else if (!InstrValid) begin
        chk("nop_instr", Instr, NOP_INSTR);
      end
    end
    redir = 0;
    if (!reset && take && InstrValid) begin
      n_pops++;
      last_pc  = PC;
      last_pc8 = PCPlus8;
      if (q.size() != 0) void'(q.pop_front());
      if (src) begin
        redir    = 1;
        q.delete();
        exp_addr = tgt & ~32'h3;
        if (imem_req && !ack_now) drop_pend = 1;
      end
    end
    if (ack_now) begin
      if (redir || drop_pend) begin
        drop_pend = 0;
      end else begin
        chk("fetch_addr", imem_addr, exp_addr);
        q.push_back('{pc: exp_addr, instr: memfn(exp_addr)});
        exp_addr = exp_addr + 32'd4;
      end
    end
    pr_req  = imem_req;
    pr_ack  = ack_now;
    pr_rst  = reset;
    pr_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (pr_rst || ack_now) lat_cnt = 0;
    else if (pr_req) lat_cnt++;
    if (pr_req && !pr_ack && !pr_rst) begin
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, pr_addr);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc(0, 0, 32'h0);
    reset     = 1'b0;
    q.delete();
    exp_addr  = 32'h0;
    lat_cnt   = 0;
    drop_pend = 0;
  endtask

  vec_t        tv[3];
  logic [31:0] exp_b_pc[3];
  int          kb;
  int          n0;

  initial begin
    tv[0] = '{lat: 1, pops: 4, last_pc: 32'h0000_000C};
    tv[1] = '{lat: 3, pops: 3, last_pc: 32'h0000_0018};
    tv[2] = '{lat: 0, pops: 2, last_pc: 32'h0000_0020};
    exp_b_pc[0] = 32'hFFFF_FFF8;
    exp_b_pc[1] = 32'hFFFF_FFFC;
    exp_b_pc[2] = 32'h0000_0000;

    do_reset(2);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, InstrValid}, 32'd0);
    chk("rst_instr", Instr, NOP_INSTR);
    chk("rst_pc", PC, 32'h0);
    chk("rst_pc8", PCPlus8, 32'h8);
    chk("rst_b_addr", addr_b, 32'hFFFF_FFF8);
    chk("rst_b_pc8", pc8_b, 32'h8);

    for (int i = 0; i < 3; i++) begin
      lat = tv[i].lat;
      n0  = n_pops + tv[i].pops;
      for (int c = 0; c < 200 && n_pops < n0; c++) cyc(1, 0, 32'h0);
      chk("tbl_done", {31'b0, n_pops >= n0}, 32'd1);
      chk("tbl_last_pc", last_pc, tv[i].last_pc);
    end

    do_reset(1);
    lat = 1;
    repeat (30) cyc(0, 0, 32'h0);
    chk("full_count", q.size(), 32'd2);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_pc", PC, 32'h0);
    cyc(1, 0, 32'h0);
    for (int c = 0; c < 5 && !imem_req; c++) cyc(1, 0, 32'h0);
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h8);

    do_reset(1);
    lat = 3;
    for (int c = 0; c < 100 && !(imem_req && imem_addr == 32'h8); c++)
      cyc(1, 0, 32'h0);
    for (int c = 0; c < 100 && !(imem_req && imem_addr == 32'hC &&
         InstrValid && lat_cnt < lat); c++)
      cyc(0, 0, 32'h0);
    chk("t3_armed", {31'b0, InstrValid && imem_addr == 32'hC}, 32'd1);
    cyc(1, 1, 32'h100);
    chk("t3_valid", {31'b0, InstrValid}, 32'd0);
    chk("t3_discard_req", {31'b0, imem_req}, 32'd1);
    for (int c = 0; c < 100 && !(imem_req && imem_addr == 32'h100); c++)
      cyc(1, 0, 32'h0);
    chk("t3_new_addr", imem_addr, 32'h100);
    n0 = n_pops + 1;
    for (int c = 0; c < 100 && n_pops < n0; c++) cyc(1, 0, 32'h0);
    chk("t3_pc", last_pc, 32'h100);
    chk("t3_pc8", last_pc8, 32'h108);

    do_reset(1);
    lat = 1;
    for (int c = 0; c < 100 && !(imem_req && imem_addr == 32'h8); c++)
      cyc(1, 0, 32'h0);
    for (int c = 0; c < 100 && !(imem_req && imem_addr == 32'hC &&
         InstrValid && lat_cnt >= lat); c++)
      cyc(0, 0, 32'h0);
    chk("t4_armed", {31'b0, InstrValid && imem_addr == 32'hC}, 32'd1);
    cyc(1, 1, 32'h203);
    chk("t4_req_idle", {31'b0, imem_req}, 32'd0);
    chk("t4_valid", {31'b0, InstrValid}, 32'd0);
    cyc(0, 0, 32'h0);
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    n0 = n_pops + 1;
    for (int c = 0; c < 100 && n_pops < n0; c++) cyc(1, 0, 32'h0);
    chk("t4_pc", last_pc, 32'h200);

    do_reset(1);
    b_en = 1;
    kb   = 0;
    for (int c = 0; c < 40 && kb < 3; c++) begin
      if (valid_b) begin
        chk("b_pc", pc_b, exp_b_pc[kb]);
        chk("b_pc8", pc8_b, exp_b_pc[kb] + 32'd8);
        chk("b_instr", instr_b, memfn(exp_b_pc[kb]));
        kb++;
      end
      cyc(0, 0, 32'h0);
    end
    chk("b_count", kb, 32'd3);
    b_en = 0;

    do_reset(1);
    lat = 5;
    for (int c = 0; c < 100 && !(imem_req && InstrValid); c++)
      cyc(0, 0, 32'h0);
    chk("t6_armed", {31'b0, imem_req && InstrValid}, 32'd1);
    do_reset(1);
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_valid", {31'b0, InstrValid}, 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    for (int c = 0; c < 10 && !imem_req; c++) cyc(1, 0, 32'h0);
    chk("t6_refetch", imem_addr, 32'h0);
    n0 = n_pops + 1;
    for (int c = 0; c < 100 && n_pops < n0; c++) cyc(1, 0, 32'h0);
    chk("t6_pc", last_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
